// File: rtl/count_uart_tx_if.sv
// -----------------------------------------------------------------------------
// count_uart_tx_if
//   Request channel between the 8-bit up/load counter and the UART transmitter.
//
//   Signals:
//     count_in  counter value offered for transmission
//     in_valid  explicit request to send count_in
//     auto_en   1 = transmitter sends by itself whenever count_in differs from
//               the last value it sent
//     in_ready  transmitter can accept a transfer (in_valid && in_ready)
//
//   Modports:
//     master  counter side (drives count_in, in_valid, auto_en)
//     slave   transmitter side (drives in_ready)
// -----------------------------------------------------------------------------
interface count_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] count_in;
  logic              in_valid;
  logic              auto_en;
  logic              in_ready;

  modport master (
    output count_in,
    output in_valid,
    output auto_en,
    input  in_ready
  );

  modport slave (
    input  count_in,
    input  in_valid,
    input  auto_en,
    output in_ready
  );
endinterface : count_uart_tx_if

// File: rtl/count_uart_tx.sv
// -----------------------------------------------------------------------------
// count_uart_tx
//   Serialises a counter value onto a single UART TX pin, LSB first, for an
//   off-chip logger. A frame is launched by an explicit valid/ready request or,
//   with auto_en set, whenever the count differs from the last value sent.
//
//   Build option:
//     COUNT_UART_TX_PARITY_EN  defined   -> 8E1 frame, even parity bit after DATA
//                              undefined -> 8N1 frame, no parity logic at all
//
//   Parameters:
//     CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//     DATA_W        payload width (>= 2), must match the counter width
//
//   Ports:
//     clk   system clock, all state updates on the rising edge
//     rst   synchronous, active-high reset
//     req   request channel (count_uart_tx_if.slave: count_in, in_valid,
//           auto_en in; in_ready out)
//     tx    UART serial output, idle level 1, driven straight from a register
//     busy  high while a frame is in progress
//     done  one-cycle pulse during the last cycle of the stop bit
// -----------------------------------------------------------------------------
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  count_uart_tx_if.slave          req,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef COUNT_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] last_sent;
  logic              tx_q;

  logic bit_end;
  logic trigger;
  logic accept;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // done marks the last stop-bit cycle. The transmitter is ready again in that
  // same cycle, so a pending request launches the next start bit on the very
  // edge that would otherwise enter IDLE: back-to-back frames have no gap.
  assign done         = (state == ST_STOP) && bit_end;
  assign busy         = (state != ST_IDLE);
  assign req.in_ready = (state == ST_IDLE) || done;

  // An explicit request and an auto trigger in the same cycle are one event.
  assign trigger = req.in_valid | (req.auto_en & (req.count_in != last_sent));
  assign accept  = req.in_ready & trigger;

  assign tx = tx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      last_sent <= '0;
      tx_q      <= 1'b1;
    end else if (accept) begin
      // Capture the payload; the start bit goes out from this edge.
      state     <= ST_START;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= req.count_in;
      last_sent <= req.count_in;
      tx_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
        end

        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef COUNT_UART_TX_PARITY_EN
              // last_sent holds the payload of the frame in flight.
              state <= ST_PARITY;
              tx_q  <= ^last_sent;
`else
              state <= ST_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              // tx takes the next bit now; the shift keeps it at index 0.
              bit_idx <= bit_idx + IDX_W'(1);
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

`ifdef COUNT_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            baud_cnt <= '0;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
          tx_q <= 1'b1;
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule : count_uart_tx

// File: tb/tb_count_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_count_uart_tx
//   Self-checking bench for count_uart_tx with CLKS_PER_BIT = 4. The reference
//   model keeps a queue holding the expected tx level for every remaining cycle
//   of the frame in flight; a frame is appended as a whole bit pattern
//   (start, LSB-first payload, optional parity, stop) when a transfer is
//   accepted. busy, done and in_ready follow from the queue length.
// -----------------------------------------------------------------------------
module tb_count_uart_tx;

  localparam int CPB    = 4;
  localparam int DATA_W = 8;
`ifdef COUNT_UART_TX_PARITY_EN
  localparam int NBITS  = DATA_W + 3;
`else
  localparam int NBITS  = DATA_W + 2;
`endif
  localparam int FRAME  = NBITS * CPB;

  logic clk = 1'b0;
  logic rst;
  logic tx, busy, done;

  count_uart_tx_if #(.DATA_W(DATA_W)) bus ();

  count_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DATA_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (bus),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state
  logic            exp_q[$];
  logic [DATA_W-1:0] model_last = '0;
  int done_cnt = 0;
  int busy_cnt = 0;

  task automatic push_frame(input logic [DATA_W-1:0] v);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(v[i]);
`ifdef COUNT_UART_TX_PARITY_EN
    bits.push_back(^v);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < CPB; k++) exp_q.push_back(bits[i]);
  endtask

  // One clock cycle: check outputs, apply inputs for the coming edge, advance model.
  task automatic step(input logic r, input logic v, input logic a,
                      input logic [DATA_W-1:0] c);
    logic e_tx, e_busy, e_done, e_rdy;
    int   n;
    n      = exp_q.size();
    e_tx   = (n > 0) ? exp_q[0] : 1'b1;
    e_busy = (n > 0);
    e_done = (n == 1);
    e_rdy  = (n <= 1);
    check("tx",       32'(tx),           32'(e_tx));
    check("busy",     32'(busy),         32'(e_busy));
    check("done",     32'(done),         32'(e_done));
    check("in_ready", 32'(bus.in_ready), 32'(e_rdy));
    done_cnt += (done === 1'b1) ? 1 : 0;
    busy_cnt += (busy === 1'b1) ? 1 : 0;

    rst          = r;
    bus.in_valid = v;
    bus.auto_en  = a;
    bus.count_in = c;

    if (r) begin
      exp_q.delete();
      model_last = '0;
    end else begin
      if (n > 0) void'(exp_q.pop_front());
      if (e_rdy && (v || (a && (c != model_last)))) begin
        push_frame(c);
        model_last = c;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input logic [DATA_W-1:0] c);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, c);
  endtask

  initial begin
    logic r, v, a;
    logic [DATA_W-1:0] c;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.auto_en  = 1'b0;
    bus.count_in = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset held, then a long quiet idle.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    done_cnt = 0;
    idle(50, 8'h00);
    check("idle_done_count", 32'(done_cnt), 32'd0);

    // Single frame of 0xA5.
    done_cnt = 0; busy_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    idle(FRAME + 8, 8'hA5);
    check("a5_done_count", 32'(done_cnt), 32'd1);
    check("a5_busy_len",   32'(busy_cnt), 32'(FRAME));

    // Back-to-back: in_valid held with 0x00, then 0xFF mid-frame.
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < FRAME / 2; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < FRAME; i++)     step(1'b0, 1'b1, 1'b0, 8'hFF);
    idle(FRAME + 8, 8'hFF);
    check("b2b_done_count", 32'(done_cnt), 32'd2);
    check("b2b_busy_len",   32'(busy_cnt), 32'(2 * FRAME));

    // Auto mode: reset clears last_sent, count steps 0 -> 3 -> 3 -> 7.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 10; i++)        step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++)        step(1'b0, 1'b0, 1'b1, 8'h03);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 1'b1, 8'h07);
    idle(10, 8'h07);
    check("auto_done_count", 32'(done_cnt), 32'd2);
    check("auto_busy_len",   32'(busy_cnt), 32'(2 * FRAME));

    // Reset in DATA bit 3 of 0x5A, then an intact frame.
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    idle(CPB * 4 + 1, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    idle(3, 8'h5A);
    check("abort_done_count", 32'(done_cnt), 32'd0);
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    idle(FRAME + 4, 8'h5A);
    check("post_abort_done_count", 32'(done_cnt), 32'd1);

`ifdef COUNT_UART_TX_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 8'h07);
    idle(FRAME + 2, 8'h07);
    step(1'b0, 1'b1, 1'b0, 8'h03);
    idle(FRAME + 2, 8'h03);
`endif

    // Randomized traffic.
    a = 1'b0;
    c = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) a = ~a;
      if ($urandom_range(0, 29) == 0) c = 8'($urandom_range(0, 255));
      step(r, v, a, c);
    end
    idle(FRAME + 4, c);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_count_uart_tx
